// File: rtl/price_fifo_reader_if.sv
// price_fifo_reader_if: FIFO pop side plus delta/sum result handshake of the price reader.
interface price_fifo_reader_if #(
    parameter int WIDTH = 16,
    parameter int SUM_W = WIDTH + 5
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gain;
    logic [WIDTH-1:0] loss;
    logic [SUM_W-1:0] gain_sum;
    logic [SUM_W-1:0] loss_sum;
    logic             window_full;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_rd_en, out_valid, gain, loss, gain_sum, loss_sum, window_full
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_rd_en, out_valid, gain, loss, gain_sum, loss_sum, window_full
    );
endinterface

// File: rtl/price_fifo_reader.sv
// price_fifo_reader: pops prices one at a time, emits gain/loss deltas and their sliding-window sums.
module price_fifo_reader #(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 14,
    parameter int SUM_W  = WIDTH + 5
) (
    input logic clk,
    input logic rst,
    price_fifo_reader_if.master bus
);
    localparam int CW = $clog2(PERIOD + 1);
    localparam int IW = $clog2(PERIOD);

    typedef enum logic [2:0] {IDLE, READ, LATCH, UPDATE, OUT} state_t;

    state_t           state;
    logic [WIDTH-1:0] cur_price;
    logic [WIDTH-1:0] prev_price;
    logic [WIDTH-1:0] d_gain;
    logic [WIDTH-1:0] d_loss;
    logic [WIDTH-1:0] gbuf [PERIOD];
    logic [WIDTH-1:0] lbuf [PERIOD];
    logic [CW-1:0]    count;
    logic [IW-1:0]    widx;
    logic             primed;
    logic             full;
    logic [SUM_W-1:0] gsum_nxt;
    logic [SUM_W-1:0] lsum_nxt;

    // Once the window is full, widx points at the oldest entry, which is retired as the new one lands.
    always_comb begin
        d_gain   = cur_price > prev_price ? cur_price - prev_price : '0;
        d_loss   = cur_price < prev_price ? prev_price - cur_price : '0;
        full     = count == CW'(PERIOD);
        gsum_nxt = bus.gain_sum + SUM_W'(d_gain) - (full ? SUM_W'(gbuf[widx]) : '0);
        lsum_nxt = bus.loss_sum + SUM_W'(d_loss) - (full ? SUM_W'(lbuf[widx]) : '0);
    end

    always_ff @(posedge clk)
        if (state == UPDATE && primed) begin
            gbuf[widx] <= d_gain;
            lbuf[widx] <= d_loss;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state           <= IDLE;
            bus.fifo_rd_en  <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.gain        <= '0;
            bus.loss        <= '0;
            bus.gain_sum    <= '0;
            bus.loss_sum    <= '0;
            bus.window_full <= 1'b0;
            cur_price       <= '0;
            prev_price      <= '0;
            count           <= '0;
            widx            <= '0;
            primed          <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (!bus.fifo_empty) begin
                        bus.fifo_rd_en <= 1'b1;
                        state          <= READ;
                    end
                READ: begin
                    bus.fifo_rd_en <= 1'b0;
                    state          <= LATCH;
                end
                LATCH: begin
                    cur_price <= bus.fifo_dout;
                    state     <= UPDATE;
                end
                UPDATE: begin
                    prev_price <= cur_price;
                    if (!primed) begin
                        primed <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        bus.gain        <= d_gain;
                        bus.loss        <= d_loss;
                        bus.gain_sum    <= gsum_nxt;
                        bus.loss_sum    <= lsum_nxt;
                        bus.window_full <= bus.window_full | (count == CW'(PERIOD - 1));
                        count           <= full ? count : count + 1'b1;
                        widx            <= widx == IW'(PERIOD - 1) ? '0 : widx + 1'b1;
                        bus.out_valid   <= 1'b1;
                        state           <= OUT;
                    end
                end
                OUT:
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule
